// File: rtl/bist_pkg.sv
// Shared constants and state encoding for the BIST controller and its
// failure-capture block.
package bist_pkg;

    localparam int DATA_W    = 4;
    localparam int STATUS_W  = 16;
    localparam int ERR_CNT_W = 5;

    localparam int ST_IN   = 12;
    localparam int ST_EXP  = 8;
    localparam int ST_GOT  = 4;
    localparam int ST_CODE = 0;

    localparam logic [3:0] ERR_NONE   = 4'h0;
    localparam logic [3:0] ERR_SINGLE = 4'h1;
    localparam logic [3:0] ERR_MULTI  = 4'h2;
    localparam logic [3:0] ERR_ABORT  = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_e;

endpackage

// File: rtl/bist_fail_capture.sv
// Mismatch counter and first-failure status word. The word is written only
// on clear, on a compare mismatch and on abort, so it stays static in DONE.
module bist_fail_capture
    import bist_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 cmp_i,
    input  logic                 abort_i,
    input  logic [DATA_W-1:0]    pattern_i,
    input  logic [DATA_W-1:0]    exp_i,
    input  logic [DATA_W-1:0]    got_i,
    output logic [STATUS_W-1:0]  status_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [STATUS_W-1:0]  status_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 captured_q;
    logic                 mismatch;

    assign mismatch = (exp_i != got_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            status_q   <= '0;
            err_cnt_q  <= '0;
            captured_q <= 1'b0;
        end else if (abort_i) begin
            // An earlier captured failure is more useful than the abort point
            status_q[ST_CODE +: DATA_W] <= ERR_ABORT;
            if (!captured_q) begin
                status_q[ST_IN  +: DATA_W] <= pattern_i;
                status_q[ST_EXP +: DATA_W] <= '0;
                status_q[ST_GOT +: DATA_W] <= '0;
            end
        end else if (cmp_i && mismatch) begin
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (!captured_q) begin
                status_q[ST_IN   +: DATA_W] <= pattern_i;
                status_q[ST_EXP  +: DATA_W] <= exp_i;
                status_q[ST_GOT  +: DATA_W] <= got_i;
                status_q[ST_CODE +: DATA_W] <= ERR_SINGLE;
                captured_q                  <= 1'b1;
            end else begin
                status_q[ST_CODE +: DATA_W] <= ERR_MULTI;
            end
        end
    end

    assign status_o  = status_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/bist_controller.sv
// Exhaustive-pattern BIST sequencer: applies vectors 0..NUM_PATTERNS-1 to the
// CUT, waits CUT_LATENCY cycles, and compares the response with the golden model.
module bist_controller
    import bist_pkg::*;
#(
    parameter int CUT_LATENCY  = 1,
    parameter int NUM_PATTERNS = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    output logic [DATA_W-1:0]    CUT_IN,
    input  logic [DATA_W-1:0]    CUT_OUT,
    input  logic [DATA_W-1:0]    EXP_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [STATUS_W-1:0]  STATUS_REG
);

    localparam logic [4:0] LAST_PATTERN = 5'(NUM_PATTERNS - 1);
    localparam logic [3:0] SETTLE_LOAD  = 4'(CUT_LATENCY - 1);

    state_e            state_q;
    logic [4:0]        pattern_q;
    logic [4:0]        pattern_d;
    logic [3:0]        settle_q;
    logic [DATA_W-1:0] cut_in_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic start_ok;
    logic abort_ok;
    logic cmp_stb;
    logic mismatch;

    assign pattern_d = pattern_q + 5'd1;
    assign start_ok  = START && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign abort_ok  = ABORT && busy_q;
    assign cmp_stb   = (state_q == S_COMPARE) && !ABORT;
    assign mismatch  = (CUT_OUT != EXP_OUT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            settle_q  <= '0;
            cut_in_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else if (start_ok) begin
            state_q   <= S_APPLY;
            pattern_q <= '0;
            cut_in_q  <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else if (abort_ok) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_APPLY: begin
                    if (CUT_LATENCY > 0) begin
                        settle_q <= SETTLE_LOAD;
                        state_q  <= S_SETTLE;
                    end else begin
                        state_q <= S_COMPARE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= S_COMPARE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                S_COMPARE: begin
                    // CUT_IN is updated on entry to APPLY so the CUT sees it for the whole vector
                    if (pattern_q == LAST_PATTERN) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (ERR_CNT == '0) && !mismatch;
                    end else begin
                        pattern_q <= pattern_d;
                        cut_in_q  <= pattern_d[DATA_W-1:0];
                        state_q   <= S_APPLY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    bist_fail_capture u_fail_capture (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (start_ok),
        .cmp_i     (cmp_stb),
        .abort_i   (abort_ok),
        .pattern_i (pattern_q[DATA_W-1:0]),
        .exp_i     (EXP_OUT),
        .got_i     (CUT_OUT),
        .status_o  (STATUS_REG),
        .err_cnt_o (ERR_CNT)
    );

    assign CUT_IN = cut_in_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign PASS   = pass_q;

endmodule
